// File: rtl/tpu_cmd_dispatch_if.sv
// Byte-stream handshake bundle between the UART and the TPU command dispatcher.
// The master side drives commands and accepts responses.
interface tpu_cmd_dispatch_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output rx_valid, rx_data, tx_ready, input rx_ready, tx_valid, tx_data);
  modport slave  (input rx_valid, rx_data, tx_ready, output rx_ready, tx_valid, tx_data);
endinterface

// File: rtl/tpu_cmd_dispatch.sv
// UART command decoder for the MLP cores: collects opcode and payload bytes,
// issues one-cycle per-core strobes and returns status/response bytes.
module tpu_cmd_dispatch #(
  parameter int unsigned NUM_CORES      = 2,
  parameter int unsigned ACC_W          = 32,
  parameter int unsigned STATE_W        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  tpu_cmd_dispatch_if.slave            bus,
  output logic [NUM_CORES-1:0]         core_wf_push_col0,
  output logic [NUM_CORES-1:0]         core_wf_push_col1,
  output logic [NUM_CORES-1:0]         core_wf_reset,
  output logic [NUM_CORES-1:0]         core_act_valid,
  output logic [NUM_CORES-1:0]         core_start,
  output logic [7:0]                   core_wf_data,
  output logic [15:0]                  core_act_data,
  output logic [NUM_CORES-1:0]         core_weights_ready,
  input  logic [NUM_CORES*STATE_W-1:0] core_state,
  input  logic [NUM_CORES*ACC_W-1:0]   core_acc0,
  output logic                         busy,
  output logic                         err
);

  localparam int unsigned RESP_N = 1 + ACC_W / 8;
  localparam int unsigned BUF_W  = 8 * RESP_N;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W  = $clog2(RESP_N + 1);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_EXEC, S_RESP} state_t;

  state_t               r_state, w_next;
  logic                 r_rx_ready;
  logic [3:0]           r_op, r_k;
  logic [1:0]           r_rem;
  logic                 r_pidx;
  logic [7:0]           r_b0, r_b1;
  logic [TMO_W-1:0]     r_tmo;
  logic                 r_tmo_hit;
  logic [BUF_W-1:0]     r_buf;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_clr;
  logic                 r_err;
  logic [NUM_CORES-1:0] r_wr;

  logic                 w_rx_acc, w_tx_acc, w_tmo;
  logic [1:0]           w_len_in;
  logic                 w_known, w_kvalid, w_bad, w_need_resp, w_ex;
  logic [NUM_CORES-1:0] w_onehot;
  logic [STATE_W-1:0]   w_st_sel;
  logic [ACC_W-1:0]     w_acc_sel;
  logic [7:0]           w_st8;

  function automatic logic [1:0] payload_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h8: return 2'd1;
      4'h3:             return 2'd2;
      default:          return 2'd0;
    endcase
  endfunction

  assign w_rx_acc = bus.rx_valid && r_rx_ready;
  assign w_tx_acc = (r_state == S_RESP) && bus.tx_ready;
  assign w_len_in = payload_len(bus.rx_data[7:4]);
  assign w_tmo    = (r_state == S_PAYLOAD) && !w_rx_acc &&
                    (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  // Core select is a compare loop so out-of-range k never indexes past the buses.
  always_comb begin
    w_onehot  = '0;
    w_st_sel  = '0;
    w_acc_sel = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (32'(r_k) == i) begin
        w_onehot[i] = 1'b1;
        w_st_sel    = core_state[i*STATE_W +: STATE_W];
        w_acc_sel   = core_acc0[i*ACC_W +: ACC_W];
      end
    end
    w_st8                = '0;
    w_st8[STATE_W-1:0]   = w_st_sel;
  end

  assign w_known     = r_op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8};
  assign w_kvalid    = 32'(r_k) < NUM_CORES;
  assign w_bad       = r_tmo_hit || !w_known || (r_op != 4'h8 && !w_kvalid);
  assign w_need_resp = w_bad || r_op == 4'h4 || r_op == 4'h5;
  assign w_ex        = (r_state == S_EXEC) && !w_bad;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_rx_acc) w_next = (w_len_in != 2'd0) ? S_PAYLOAD : S_EXEC;
      S_PAYLOAD: if ((w_rx_acc && r_rem == 2'd1) || w_tmo) w_next = S_EXEC;
      S_EXEC:    w_next = w_need_resp ? S_RESP : S_IDLE;
      S_RESP:    if (w_tx_acc && r_cnt == CNT_W'(1)) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_ready <= 1'b0;
      r_op       <= '0;
      r_k        <= '0;
      r_rem      <= '0;
      r_pidx     <= 1'b0;
      r_b0       <= '0;
      r_b1       <= '0;
      r_tmo      <= '0;
      r_tmo_hit  <= 1'b0;
      r_buf      <= '0;
      r_cnt      <= '0;
      r_clr      <= 1'b0;
      r_err      <= 1'b0;
      r_wr       <= '0;
    end else begin
      r_rx_ready <= (w_next == S_IDLE) || (w_next == S_PAYLOAD);
      unique case (r_state)
        S_IDLE: if (w_rx_acc) begin
          r_op      <= bus.rx_data[7:4];
          r_k       <= bus.rx_data[3:0];
          r_rem     <= w_len_in;
          r_pidx    <= 1'b0;
          r_tmo     <= '0;
          r_tmo_hit <= 1'b0;
        end
        S_PAYLOAD: begin
          if (w_rx_acc) begin
            if (!r_pidx) r_b0 <= bus.rx_data;
            else         r_b1 <= bus.rx_data;
            r_pidx <= 1'b1;
            r_rem  <= r_rem - 2'd1;
            r_tmo  <= '0;
          end else if (w_tmo) begin
            r_tmo_hit <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_EXEC: begin
          r_clr <= 1'b0;
          r_cnt <= CNT_W'(1);
          if (w_bad) begin
            r_err <= 1'b1;
            r_buf <= BUF_W'(8'hEE);
          end else if (r_op == 4'h4) begin
            if (w_st_sel == '0) begin
              r_wr  <= r_wr | w_onehot;
              r_buf <= BUF_W'(8'hAA);
            end else begin
              r_buf <= BUF_W'(8'hEB);
            end
          end else if (r_op == 4'h5) begin
            r_buf <= {w_acc_sel, w_st8};
            r_cnt <= CNT_W'(RESP_N);
            r_clr <= 1'b1;
          end else if (r_op == 4'h6) begin
            r_wr <= r_wr & ~w_onehot;
          end
        end
        S_RESP: if (w_tx_acc) begin
          r_buf <= r_buf >> 8;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1) && r_clr) r_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    core_wf_push_col0 = '0;
    core_wf_push_col1 = '0;
    core_wf_reset     = '0;
    core_act_valid    = '0;
    core_start        = '0;
    if (w_ex) begin
      unique case (r_op)
        4'h1:    core_wf_push_col0 = w_onehot;
        4'h8:    core_wf_push_col0 = '1;
        4'h2:    core_wf_push_col1 = w_onehot;
        4'h3:    core_act_valid    = w_onehot;
        4'h4:    if (w_st_sel == '0) core_start = w_onehot;
        4'h6:    core_wf_reset     = w_onehot;
        default: ;
      endcase
    end
  end

  assign core_wf_data       = r_b0;
  assign core_act_data      = {r_b1, r_b0};
  assign core_weights_ready = r_wr;
  assign busy               = (r_state != S_IDLE);
  assign err                = r_err;
  assign bus.rx_ready       = r_rx_ready;
  assign bus.tx_valid       = (r_state == S_RESP);
  assign bus.tx_data        = r_buf[7:0];

endmodule

// File: doc/tpu_cmd_dispatch.md
TPU_CMD_DISPATCH -- requirements
Module: tpu_cmd_dispatch

Interface
REQ-001 Parameters: NUM_CORES, default 2, MLP cores served (1..8); ACC_W, default 32, accumulator width (multiple of 8); STATE_W, default 4, core state width; TIMEOUT_CYCLES, default 4096, max idle cycles between payload bytes.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rx_valid/rx_data/rx_ready  in/in/out  1/8/1  command byte stream from UART RX; byte accepted when valid&ready.
REQ-005 tx_valid/tx_data/tx_ready  out/out/in  1/8/1  response byte stream to UART TX; byte sent when valid&ready.
REQ-006 core_wf_push_col0, core_wf_push_col1, core_wf_reset, core_act_valid, core_start  out  NUM_CORES each  one-hot per-core strobes.
REQ-007 core_wf_data out 8, core_act_data out 16: shared payload buses, valid with strobes.
REQ-008 core_weights_ready  out  NUM_CORES  per-core level.
REQ-009 core_state in NUM_CORES*STATE_W; core_acc0 in NUM_CORES*ACC_W: per-core status, core i at slice i.
REQ-010 busy out 1 (FSM not IDLE); err out 1 (sticky error flag).

Function
REQ-011 Opcode byte: [7:4] op, [3:0] core index k; accepted only in IDLE.
REQ-012 Ops: 0x1 weight col0 (1 payload byte); 0x2 weight col1 (1); 0x3 activation (2 bytes, low then high); 0x4 start (0); 0x5 status read (0); 0x6 FIFO reset (0); 0x8 broadcast weight col0 to all cores (1, k ignored).
REQ-013 FSM states IDLE, PAYLOAD, EXEC, RESP; IDLE->PAYLOAD if payload>0 else EXEC; PAYLOAD->EXEC on final byte; EXEC->RESP if response needed else IDLE; RESP->IDLE after last byte handshakes.
REQ-014 rx_ready = 1 only in IDLE and PAYLOAD; 0 otherwise.
REQ-015 EXEC lasts exactly 1 cycle; strobes for the command are high only during that cycle, exactly one cycle after the final byte (or opcode) is accepted.
REQ-016 0x1/0x2: push bit k high, core_wf_data = payload; 0x8: push_col0 all NUM_CORES bits high.
REQ-017 0x3: core_act_valid[k] high, core_act_data = {high,low}.
REQ-018 0x4: if core_state[k]==0, core_weights_ready[k] set to 1, core_start[k] pulsed, response 0xAA; else no pulse, response 0xEB.
REQ-019 0x6: core_wf_reset[k] pulsed; core_weights_ready[k] cleared same cycle.
REQ-020 0x5: in EXEC snapshot core_state[k] (zero-extended to 8 bits) and core_acc0[k]; response = state byte then ACC_W/8 acc bytes, little-endian; later input changes do not alter the response.
REQ-021 Invalid k (k >= NUM_CORES, non-broadcast): payload still consumed, no strobe, response 0xEE, err set.
REQ-022 Unknown op: no payload, response 0xEE, err set.
REQ-023 Timeout: counter restarts on each accepted byte in PAYLOAD; reaching TIMEOUT_CYCLES -> discard command, response 0xEE, err set.
REQ-024 tx_data stable and tx_valid held while tx_valid&!tx_ready; tx_valid=0 outside RESP.
REQ-025 err cleared only by reset or by a successful 0x5 to a valid core after its response completes.
REQ-026 Outputs from registers; no combinational path rx->tx.

Reset
REQ-027 During rst: FSM IDLE, all strobes 0, core_weights_ready 0, tx_valid 0, rx_ready 0, busy 0, err 0, timeout counter 0; rx_ready goes 1 first cycle after rst deasserts.
REQ-028 rst mid-command or mid-response aborts it; no strobe or tx byte is issued afterward for that command.

Verification
REQ-029 Bytes 0x11,0x5A -> core_wf_push_col0=2'b10, core_wf_data=0x5A for one cycle, one cycle after 0x5A accepted; no tx.
REQ-030 0x30,0x34,0x12 -> core_act_valid[0] one cycle, core_act_data=0x1234.
REQ-031 0x40 with core_state[0]=0 -> core_start[0] pulse, weights_ready[0]=1, tx 0xAA; repeat with core_state[0]=3 -> tx 0xEB, no pulse.
REQ-032 0x51, core_state[1]=2, core_acc0[1]=0x80000001, tx_ready toggling 1/0 -> tx 0x02,0x01,0x00,0x00,0x80 in order, data stable while stalled.
REQ-033 0x80,0x7F -> push_col0=all ones; 0x1F,0x00 (NUM_CORES=2) -> no strobe, tx 0xEE, err=1; then 0x50 -> err=0 after 5 bytes.
REQ-034 0x30,0x01 then no byte for TIMEOUT_CYCLES -> tx 0xEE, err=1, no act_valid; rst during RESP -> tx_valid 0 next cycle, FSM IDLE.
